// File: rtl/unidade_controle.sv
// unidade_controle: multicycle control FSM for a small RV64-subset datapath.
module unidade_controle (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       reset_wire,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       aluout_write,
  output logic       mem_wr,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] operacao,
  output logic       ilegal,
  output logic [3:0] estado_dbg
);
  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_BUSCA     = 4'd1,
    S_ESPERA    = 4'd2,
    S_DECODE    = 4'd3,
    S_EXEC_R    = 4'd4,
    S_EXEC_I    = 4'd5,
    S_WB_ALU    = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_LOAD  = 4'd8,
    S_WB_LOAD   = 4'd9,
    S_MEM_STORE = 4'd10,
    S_BRANCH    = 4'd11,
    S_ILEGAL    = 4'd12
  } state_t;
  state_t state_q, state_d;
  logic [2:0] logic_op, r_op, i_op;
  logic r_ok, i_ok, m_ok, b_ok;
  assign logic_op = funct3 == 3'b111 ? 3'b011 :
                    funct3 == 3'b110 ? 3'b100 :
                    funct3 == 3'b100 ? 3'b101 : 3'b000;
  assign r_op = funct3 == 3'b000 ? (funct7_5 ? 3'b010 : 3'b001) : logic_op;
  assign i_op = funct3 == 3'b000 ? 3'b001 : logic_op;
  assign r_ok = opcode == 7'b0110011 && r_op != 3'b000;
  assign i_ok = opcode == 7'b0010011 && i_op != 3'b000;
  assign m_ok = (opcode == 7'b0000011 || opcode == 7'b0100011) && funct3 == 3'b011;
  assign b_ok = opcode == 7'b1100011 && funct3[2:1] == 2'b00;
  assign estado_dbg = state_q;
  always_ff @(posedge CLK) state_q <= RST ? S_RESET : state_d;
  always_comb begin
    state_d      = S_RESET;
    reset_wire   = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    aluout_write = 1'b0;
    mem_wr       = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    operacao     = 3'b000;
    ilegal       = 1'b0;
    case (state_q)
      S_RESET: begin
        reset_wire = 1'b1;
        state_d    = S_BUSCA;
      end
      S_BUSCA: state_d = S_ESPERA;
      S_ESPERA: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        operacao  = 3'b001;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b10;
        operacao     = 3'b001;
        aluout_write = 1'b1;
        state_d      = r_ok ? S_EXEC_R : i_ok ? S_EXEC_I : m_ok ? S_MEM_ADDR :
                       b_ok ? S_BRANCH : S_ILEGAL;
      end
      S_EXEC_R: begin
        alu_src_a    = 2'b01;
        operacao     = r_op;
        aluout_write = 1'b1;
        state_d      = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        operacao     = i_op;
        aluout_write = 1'b1;
        state_d      = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_BUSCA;
      end
      S_MEM_ADDR: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        operacao     = 3'b001;
        aluout_write = 1'b1;
        state_d      = opcode == 7'b0000011 ? S_MEM_LOAD : S_MEM_STORE;
      end
      S_MEM_LOAD: state_d = S_WB_LOAD;
      S_WB_LOAD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_BUSCA;
      end
      S_MEM_STORE: begin
        mem_wr  = 1'b1;
        state_d = S_BUSCA;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        operacao  = 3'b010;
        pc_src    = 1'b1;
        pc_write  = funct3[0] ? ~zero : zero;
        state_d   = S_BUSCA;
      end
      S_ILEGAL: begin
        ilegal  = 1'b1;
        state_d = S_ILEGAL;
      end
      default: state_d = S_RESET;
    endcase
    // a reset arriving mid-instruction must not let any architectural write through
    if (RST) begin
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      aluout_write = 1'b0;
      mem_wr       = 1'b0;
      reg_write    = 1'b0;
    end
  end
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: random and directed instruction streams against a per-cycle output model.
module tb_unidade_controle;
  logic       CLK, RST, funct7_5, zero;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       reset_wire, pc_write, pc_src, ir_write, aluout_write, mem_wr, reg_write, mem_to_reg, ilegal;
  logic [1:0] alu_src_a, alu_src_b;
  logic [2:0] operacao;
  logic [3:0] estado_dbg;
  int checks = 0, passed = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs;

  unidade_controle dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .reset_wire(reset_wire), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .aluout_write(aluout_write), .mem_wr(mem_wr), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .operacao(operacao), .ilegal(ilegal),
    .estado_dbg(estado_dbg)
  );

  assign obs = {estado_dbg, reset_wire, pc_write, pc_src, ir_write, aluout_write, mem_wr,
                reg_write, mem_to_reg, alu_src_a, alu_src_b, operacao, ilegal};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [19:0] mk(input int st, input logic rw, pw, ps, iw, aw, mw, rg, mr,
                                     input logic [1:0] a, b, input logic [2:0] op, input logic il);
    logic [3:0] s;
    s = st[3:0];
    return {s, rw, pw, ps, iw, aw, mw, rg, mr, a, b, op, il};
  endfunction

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic f7, input logic imm);
    case (f3)
      3'b000:  return (f7 && !imm) ? 3'd2 : 3'd1;
      3'b111:  return 3'd3;
      3'b110:  return 3'd4;
      3'b100:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Expected snapshot sequence, BUSCA onwards, for one instruction; illegal ones get n_ill ILEGAL cycles.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                       input int n_ill, output bit ill);
    exp_q.delete();
    ill = 0;
    exp_q.push_back(mk(1, 0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 0));
    exp_q.push_back(mk(2, 0,1,0,1,0,0,0,0, 2'd0, 2'd1, 3'd1, 0));
    exp_q.push_back(mk(3, 0,0,0,0,1,0,0,0, 2'd2, 2'd2, 3'd1, 0));
    if (op == 7'b0110011 && alu_op(f3, f7, 0) != 0) begin
      exp_q.push_back(mk(4, 0,0,0,0,1,0,0,0, 2'd1, 2'd0, alu_op(f3, f7, 0), 0));
      exp_q.push_back(mk(6, 0,0,0,0,0,0,1,0, 2'd0, 2'd0, 3'd0, 0));
    end else if (op == 7'b0010011 && alu_op(f3, f7, 1) != 0) begin
      exp_q.push_back(mk(5, 0,0,0,0,1,0,0,0, 2'd1, 2'd2, alu_op(f3, f7, 1), 0));
      exp_q.push_back(mk(6, 0,0,0,0,0,0,1,0, 2'd0, 2'd0, 3'd0, 0));
    end else if ((op == 7'b0000011 || op == 7'b0100011) && f3 == 3'b011) begin
      exp_q.push_back(mk(7, 0,0,0,0,1,0,0,0, 2'd1, 2'd2, 3'd1, 0));
      if (op == 7'b0000011) begin
        exp_q.push_back(mk(8, 0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 0));
        exp_q.push_back(mk(9, 0,0,0,0,0,0,1,1, 2'd0, 2'd0, 3'd0, 0));
      end else
        exp_q.push_back(mk(10, 0,0,0,0,0,1,0,0, 2'd0, 2'd0, 3'd0, 0));
    end else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
      exp_q.push_back(mk(11, 0, (f3 == 3'b000) ? z : !z, 1,0,0,0,0,0, 2'd1, 2'd0, 3'd2, 0));
    end else begin
      ill = 1;
      for (int i = 0; i < n_ill; i++) exp_q.push_back(mk(12, 0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 1));
    end
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
  endtask

  task automatic run_seq(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (obs !== exp_q[i]) $display("FAIL %s cyc%0d: got %h expected %h (op=%b f3=%b f7=%b z=%b)",
                                     name, i + 1, obs, exp_q[i], opcode, funct3, funct7_5, zero);
      else passed++;
    end
  endtask

  task automatic pulse_reset(input string name);
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (obs !== mk(0, 1,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 0))
      $display("FAIL %s held: got %h expected %h", name, obs, mk(0, 1,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 0));
    else passed++;
    RST = 1'b0;
    #1;
    checks++;
    if (obs !== mk(0, 1,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 0))
      $display("FAIL %s released: got %h expected %h", name, obs, mk(0, 1,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 0));
    else passed++;
  endtask

  task automatic do_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic z, input int n_ill);
    bit ill;
    set_in(op, f3, f7, z);
    build(op, f3, f7, z, n_ill, ill);
    run_seq(name, exp_q.size());
    if (ill) pulse_reset({name, "_rst"});
  endtask

  task automatic test_reset;
    set_in(7'b0110011, 3'b000, 1'b0, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    pulse_reset("reset");
  endtask

  task automatic test_directed;
    do_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 0);
    do_instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 0);
    do_instr("xor", 7'b0110011, 3'b100, 1'b0, 1'b1, 0);
    do_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 0);
    do_instr("ld", 7'b0000011, 3'b011, 1'b0, 1'b0, 0);
    do_instr("sd", 7'b0100011, 3'b011, 1'b0, 1'b0, 0);
    do_instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 0);
    do_instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 1'b1, 0);
    do_instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 0);
    do_instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 1'b0, 0);
    do_instr("after_branch", 7'b0010011, 3'b110, 1'b0, 1'b0, 0);
  endtask

  task automatic test_illegal;
    do_instr("ill_1111111", 7'b1111111, 3'b000, 1'b0, 1'b0, 20);
    do_instr("ill_r_f3_001", 7'b0110011, 3'b001, 1'b0, 1'b0, 3);
    do_instr("ill_ld_f3_010", 7'b0000011, 3'b010, 1'b0, 1'b0, 3);
    do_instr("ill_br_f3_100", 7'b1100011, 3'b100, 1'b0, 1'b0, 3);
    do_instr("post_ill_add", 7'b0110011, 3'b000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random;
    logic [6:0] op;
    logic [2:0] f3;
    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: begin op = 7'b0000011; if ($urandom_range(0, 3) != 0) f3 = 3'b011; end
        3: begin op = 7'b0100011; if ($urandom_range(0, 3) != 0) f3 = 3'b011; end
        4: begin op = 7'b1100011; f3 = 3'($urandom_range(0, 2)); end
        default: op = 7'($urandom);
      endcase
      do_instr("random", op, f3, 1'($urandom), 1'($urandom), 3);
    end
  endtask

  // Reset asserted in the cycle after n_before steps; strobes must drop in that same cycle.
  task automatic reset_at(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input int n_before, input logic [19:0] forced);
    bit ill;
    set_in(op, f3, 1'b0, 1'b0);
    build(op, f3, 1'b0, 1'b0, 0, ill);
    run_seq(name, n_before);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    checks++;
    if (obs !== forced) $display("FAIL %s forced: got %h expected %h", name, obs, forced);
    else passed++;
    @(posedge CLK); #1;
    checks++;
    if (estado_dbg !== 4'd0) $display("FAIL %s next_state: got %0d expected 0", name, estado_dbg);
    else passed++;
    RST = 1'b0;
  endtask

  task automatic test_reset_midinstr;
    reset_at("rst_store", 7'b0100011, 3'b011, 4, mk(10, 0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 0));
    reset_at("rst_wbload", 7'b0000011, 3'b011, 5, mk(9, 0,0,0,0,0,0,0,1, 2'd0, 2'd0, 3'd0, 0));
    reset_at("rst_espera", 7'b0110011, 3'b000, 1, mk(2, 0,0,0,0,0,0,0,0, 2'd0, 2'd1, 3'd1, 0));
    reset_at("rst_wbalu", 7'b0010011, 3'b111, 4, mk(6, 0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 0));
    do_instr("post_mid_rst", 7'b0110011, 3'b110, 1'b0, 1'b0, 0);
  endtask

  initial begin
    RST = 1'b1;
    set_in(7'b0, 3'b0, 1'b0, 1'b0);
    test_reset;
    test_directed;
    test_illegal;
    test_reset_midinstr;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK samples everything on its rising edge, and RST is sampled only on that edge.
REQ-002 CLK  in  1  system clock.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 opcode  in  7  IR[6:0].
REQ-005 funct3  in  3  IR[14:12].
REQ-006 funct7_5  in  1  IR[30].
REQ-007 zero  in  1  ALU zero flag, combinational from datapath.
REQ-008 reset_wire  out  1  datapath register reset.
REQ-009 pc_write  out  1  PC load strobe.
REQ-010 pc_src  out  1  0 = ALU result, 1 = ALUOut.
REQ-011 ir_write  out  1  IR load and PC_old capture.
REQ-012 aluout_write  out  1  ALUOut load.
REQ-013 mem_wr  out  1  data memory write.
REQ-014 reg_write  out  1  register file write.
REQ-015 mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
REQ-016 alu_src_a  out  2  00 = PC, 01 = A, 10 = PC_old.
REQ-017 alu_src_b  out  2  00 = B, 01 = constant 4, 10 = immediate.
REQ-018 operacao  out  3  000 nop, 001 add, 010 sub, 011 and, 100 or, 101 xor.
REQ-019 ilegal  out  1  illegal-instruction flag.
REQ-020 estado_dbg  out  4  current state encoding.

Function
REQ-021 States and encodings SHALL be: RESET=0, BUSCA=1, ESPERA=2, DECODE=3, EXEC_R=4, EXEC_I=5, WB_ALU=6, MEM_ADDR=7, MEM_LOAD=8, WB_LOAD=9, MEM_STORE=10, BRANCH=11, ILEGAL=12; encodings 13-15 SHALL go to RESET on the next edge.
REQ-022 Every output not listed for a state SHALL be 0 in that state; outputs SHALL be decoded from the state register, plus the inputs only where REQ-032 says so.
REQ-023 RESET: reset_wire=1; next state BUSCA.
REQ-024 BUSCA: no strobes (instruction memory addressed by PC, 1-cycle latency); next state ESPERA.
REQ-025 ESPERA: ir_write=1, alu_src_a=00, alu_src_b=01, operacao=001, pc_write=1, pc_src=0 (PC <= PC+4); next state DECODE.
REQ-026 DECODE: alu_src_a=10, alu_src_b=10, operacao=001, aluout_write=1 (branch target = PC_old + imm); next state selected by opcode/funct3:
  - 0110011 with a legal funct3/funct7_5 -> EXEC_R.
  - 0010011 with funct3 in {000,111,110,100} -> EXEC_I.
  - 0000011 or 0100011 with funct3=011 -> MEM_ADDR.
  - 1100011 with funct3 in {000,001} -> BRANCH.
  - anything else -> ILEGAL.
REQ-027 R-type op map: funct3=000 with funct7_5=0 -> 001; 000 with funct7_5=1 -> 010; 111 -> 011; 110 -> 100; 100 -> 101; all other funct3/funct7_5 combinations are illegal.
REQ-028 EXEC_R: alu_src_a=01, alu_src_b=00, operacao per REQ-027, aluout_write=1; next state WB_ALU.
REQ-029 EXEC_I: alu_src_a=01, alu_src_b=10, operacao per REQ-027 with funct7_5 ignored (000 -> add), aluout_write=1; next state WB_ALU.
REQ-030 WB_ALU: reg_write=1, mem_to_reg=0; next state BUSCA.
REQ-031 MEM_ADDR: alu_src_a=01, alu_src_b=10, operacao=001, aluout_write=1; next state MEM_LOAD if opcode=0000011, else MEM_STORE.
  - MEM_LOAD: no strobes; next state WB_LOAD.
  - WB_LOAD: reg_write=1, mem_to_reg=1; next state BUSCA.
  - MEM_STORE: mem_wr=1; next state BUSCA.
REQ-032 BRANCH: alu_src_a=01, alu_src_b=00, operacao=010, pc_src=1; pc_write = zero when funct3=000, and ~zero when funct3=001; next state BUSCA.
REQ-033 ILEGAL: ilegal=1, all strobes 0; the block SHALL remain in ILEGAL until RST.
REQ-034 Instruction latency in cycles, BUSCA to the next BUSCA: R=5, I=5, load=6, store=5, branch=4.

Reset
REQ-035 RST=1 at a rising edge SHALL force the state to RESET on that edge, regardless of current state, and hold it there while RST stays 1.
REQ-036 While RST=1, pc_write, ir_write, aluout_write, mem_wr and reg_write SHALL be forced to 0 combinationally; this also applies when reset arrives mid-instruction, e.g. in MEM_STORE or WB_LOAD.
REQ-037 After reset: estado_dbg=0, reset_wire=1, ilegal=0, operacao=000; the first cycle after RST falls SHALL be RESET, then BUSCA.

Verification
REQ-038 add x3,x1,x2 (opcode 0110011, funct3 000, funct7_5 0) -> states 1,2,3,4,6; operacao=001 in EXEC_R; reg_write=1 only in cycle 5.
REQ-039 sub (funct7_5=1) and xor (funct3 100) -> operacao 010 and 101 in EXEC_R respectively.
REQ-040 ld (0000011, funct3 011) -> 6 cycles, mem_to_reg=1 with reg_write=1 in WB_LOAD; sd (0100011) -> mem_wr=1 exactly one cycle.
REQ-041 beq with zero=1 -> pc_write=1 and pc_src=1 in BRANCH; bne with zero=1 -> pc_write=0; next state BUSCA in both cases.
REQ-042 opcode 1111111 -> ILEGAL from cycle 4, ilegal=1, all strobes 0 for 20 cycles; RST pulse -> RESET, ilegal=0.
REQ-043 RST asserted during MEM_STORE -> mem_wr=0 in that cycle, estado_dbg=0 on the next edge.
